// File: rtl/wmem_sched_pkg.sv
// wmem_sched_pkg: packet field layout, opcodes, FSM states and packet packing.
package wmem_sched_pkg;
  localparam int PKT_DEST_HI = 32;
  localparam int PKT_DEST_LO = 29;
  localparam int PKT_OP_HI = 28;
  localparam int PKT_OP_LO = 25;
  localparam int PKT_DATA_HI = 24;
  localparam int PKT_DATA_LO = 0;
  localparam logic [3:0] OP_WEIGHT = 4'd0;
  localparam logic [3:0] OP_TIMESTEP_DONE = 4'd15;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND_A, S_SEND_B, S_WAIT_TS} state_e;
  function automatic logic [PKT_DEST_HI:0] pack_pkt(input logic [3:0] dest, input logic [3:0] op,
                                                    input logic [PKT_DATA_HI:PKT_DATA_LO] data);
    pack_pkt = {dest, op, data};
  endfunction
endpackage

// File: rtl/wmem_pkt_reg.sv
// wmem_pkt_reg: registered router packet output and its valid/ready handshake.
module wmem_pkt_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pkt_valid_d,
  input  logic [32:0] pkt_data_d,
  input  logic        pkt_ready,
  output logic        pkt_valid,
  output logic [32:0] pkt_data,
  output logic        fire
);
  logic        pkt_valid_q;
  logic [32:0] pkt_data_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_valid_q <= 1'b0;
      pkt_data_q <= '0;
    end else begin
      pkt_valid_q <= pkt_valid_d;
      pkt_data_q <= pkt_data_d;
    end
  end
  assign pkt_valid = pkt_valid_q;
  assign pkt_data = pkt_data_q;
  assign fire = pkt_valid_q & pkt_ready;
endmodule

// File: rtl/wmem_sched.sv
// wmem_sched: loads a filter's weights and broadcasts them row by row to the PPEs
// once per timestep, advancing on timestep-done packets from the router.
module wmem_sched import wmem_sched_pkg::*; #(
  parameter int FILTER_SIZE = 5,
  parameter int WEIGHT_WIDTH = 8,
  parameter int FIRST_PPE = 5,
  parameter int NUM_TIMESTEPS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_start,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4:0]              wr_addr,
  input  logic [WEIGHT_WIDTH-1:0] wr_data,
  input  logic                    load_done,
  output logic                    pkt_valid,
  input  logic                    pkt_ready,
  output logic [32:0]             pkt_data,
  input  logic                    ts_valid,
  output logic                    ts_ready,
  input  logic [32:0]             ts_data,
  output logic                    busy,
  output logic                    all_sent
);
  localparam int NW = FILTER_SIZE * FILTER_SIZE;
  localparam int TSW = NUM_TIMESTEPS > 1 ? $clog2(NUM_TIMESTEPS) : 1;
  state_e                  state_q, state_d;
  logic [2:0]              row_q, row_d;
  logic [TSW-1:0]          ts_cnt_q, ts_cnt_d;
  logic                    all_sent_q, all_sent_d;
  logic [WEIGHT_WIDTH-1:0] w_q [NW];
  logic [WEIGHT_WIDTH-1:0] w_d [NW];
  logic [4:0]              base;
  logic [3:0]              dest;
  logic [32:0]             pkt_data_d;
  logic                    fire, wr_en, ts_go;
  assign wr_en = rst_n && state_q == S_LOAD && wr_valid && wr_addr < 5'(NW);
  assign ts_go = ts_valid && ts_data[PKT_OP_HI:PKT_OP_LO] == OP_TIMESTEP_DONE;
  always_comb begin
    w_d = w_q;
    if (wr_en) w_d[wr_addr] = wr_data;
    state_d = state_q;
    row_d = row_q;
    ts_cnt_d = ts_cnt_q;
    all_sent_d = 1'b0;
    case (state_q)
      S_IDLE: state_d = load_start ? S_LOAD : S_IDLE;
      S_LOAD: if (load_done) begin
        state_d = S_SEND_A;
        row_d = '0;
        ts_cnt_d = '0;
      end
      S_SEND_A: state_d = fire ? S_SEND_B : S_SEND_A;
      S_SEND_B: if (fire) begin
        if (row_q < 3'(FILTER_SIZE - 1)) begin
          row_d = row_q + 3'd1;
          state_d = S_SEND_A;
        end else if (ts_cnt_q < TSW'(NUM_TIMESTEPS - 1)) begin
          state_d = S_WAIT_TS;
        end else begin
          state_d = S_IDLE;
          all_sent_d = 1'b1;
        end
      end
      S_WAIT_TS: if (ts_go) begin
        ts_cnt_d = ts_cnt_q + 1'b1;
        row_d = '0;
        state_d = S_SEND_A;
      end
      default: state_d = S_IDLE;
    endcase
    // packet is built from next-cycle state and post-write weights so it lands with pkt_valid
    base = 5'(row_d * FILTER_SIZE);
    dest = 4'(FIRST_PPE + int'(row_d));
    pkt_data_d = state_d == S_SEND_A ?
                   pack_pkt(dest, OP_WEIGHT, 25'({w_d[base+5'd2], w_d[base+5'd1], w_d[base]})) :
                 state_d == S_SEND_B ?
                   pack_pkt(dest, OP_WEIGHT, 25'({w_d[base+5'd4], w_d[base+5'd3]})) : '0;
  end
  always_ff @(posedge clk) w_q <= w_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q <= '0;
      ts_cnt_q <= '0;
      all_sent_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      ts_cnt_q <= ts_cnt_d;
      all_sent_q <= all_sent_d;
    end
  end
  wmem_pkt_reg u_pkt_reg (
    .clk(clk),
    .rst_n(rst_n),
    .pkt_valid_d(state_d == S_SEND_A || state_d == S_SEND_B),
    .pkt_data_d(pkt_data_d),
    .pkt_ready(pkt_ready),
    .pkt_valid(pkt_valid),
    .pkt_data(pkt_data),
    .fire(fire)
  );
  assign wr_ready = state_q == S_LOAD;
  assign busy = state_q != S_IDLE;
  assign all_sent = all_sent_q;
  assign ts_ready = rst_n;
endmodule

// File: tb/tb_wmem_sched.sv
// tb_wmem_sched: random and directed stimulus against a weight-array model, with a
// scoreboard monitor checking every packet transfer and output stability under stall.
module tb_wmem_sched;
  logic clk = 0, rst_n = 0, load_start = 0, wr_valid = 0, load_done = 0, pkt_ready = 0, ts_valid = 0;
  logic [4:0] wr_addr = 0;
  logic [7:0] wr_data = 0;
  logic [32:0] ts_data = 0;
  logic wr_ready, pkt_valid, ts_ready, busy, all_sent;
  logic [32:0] pkt_data;
  int checks = 0, failures = 0, sent_cnt = 0, mode = 3, phase = 0;
  logic [32:0] exp_q[$];
  logic [32:0] got[$];
  logic [7:0] w_m[25];
  bit hold_prev = 0;
  logic [32:0] hold_data = 0;

  wmem_sched dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .load_done(load_done), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .pkt_data(pkt_data), .ts_valid(ts_valid), .ts_ready(ts_ready),
    .ts_data(ts_data), .busy(busy), .all_sent(all_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  // ready pattern: 0 always, 1 one-of-three, 2 random, 3 driven by the test itself
  always @(posedge clk) begin
    #1;
    if (mode == 0) pkt_ready = 1;
    else if (mode == 1) begin
      pkt_ready = (phase == 2);
      phase = (phase + 1) % 3;
    end else if (mode == 2) pkt_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (hold_prev) chk("hold_while_stalled", {31'd0, pkt_valid, pkt_data}, {31'd0, 1'b1, hold_data});
    if (rst_n && pkt_valid && pkt_ready) begin
      got.push_back(pkt_data);
      if (exp_q.size() == 0) chk("unexpected_pkt", {31'd0, pkt_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("pkt", {31'd0, pkt_data}, {31'd0, exp_q.pop_front()});
    end
    if (all_sent) sent_cnt++;
    hold_prev = rst_n && pkt_valid && !pkt_ready;
    hold_data = pkt_data;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bcast();
    for (int r = 0; r < 5; r++) begin
      logic [32:0] dst;
      dst = 33'((5 + r) % 16) << 29;
      exp_q.push_back(dst | (33'(w_m[5*r+2]) << 16) | (33'(w_m[5*r+1]) << 8) | 33'(w_m[5*r]));
      exp_q.push_back(dst | (33'(w_m[5*r+4]) << 8) | 33'(w_m[5*r+3]));
    end
  endtask

  task automatic start_load();
    load_start = 1;
    cyc();
    load_start = 0;
    chk("wr_ready_in_load", {63'd0, wr_ready}, 64'd1);
  endtask

  task automatic wr(input int a, input int d);
    wr_valid = 1;
    wr_addr = 5'(a);
    wr_data = 8'(d);
    cyc();
    wr_valid = 0;
    if (a < 25) w_m[a] = 8'(d);
  endtask

  task automatic finish_load();
    chk("no_valid_in_load", {63'd0, pkt_valid}, 64'd0);
    load_done = 1;
    cyc();
    load_done = 0;
    push_bcast();
    chk("valid_after_load_done", {63'd0, pkt_valid}, 64'd1);
  endtask

  task automatic send_ts(input int op, input bit expect_go);
    ts_valid = 1;
    ts_data = {4'd0, 4'(op), 25'd0};
    cyc();
    ts_valid = 0;
    if (expect_go) push_bcast();
  endtask

  task automatic drain(input string n);
    int i = 0;
    while (exp_q.size() != 0 && i < 600) begin
      cyc();
      i++;
    end
    chk({n, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    cyc();
  endtask

  initial begin
    int g0;
    repeat (3) cyc();
    chk("rst_pkt_valid", {63'd0, pkt_valid}, 64'd0);
    chk("rst_pkt_data", {31'd0, pkt_data}, 64'd0);
    chk("rst_wr_ready", {63'd0, wr_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_all_sent", {63'd0, all_sent}, 64'd0);
    chk("rst_ts_ready", {63'd0, ts_ready}, 64'd0);
    rst_n = 1;
    cyc();
    chk("ts_ready_idle", {63'd0, ts_ready}, 64'd1);
    mode = 0;
    start_load();
    for (int k = 0; k < 25; k++) wr(k, k + 1);
    finish_load();
    drain("bcast0");
    chk("pkt0", {31'd0, got[0]}, 64'h0A0030201);
    chk("pkt1", {31'd0, got[1]}, 64'h0A0000504);
    chk("pkt8", {31'd0, got[8]}, 64'h120171615);
    chk("pkt9", {31'd0, got[9]}, 64'h120001918);
    repeat (4) cyc();
    chk("wait_ts_busy", {63'd0, busy}, 64'd1);
    chk("wait_ts_no_valid", {63'd0, pkt_valid}, 64'd0);
    chk("no_all_sent_yet", 64'(sent_cnt), 64'd0);
    send_ts(3, 0);
    repeat (4) cyc();
    chk("op3_ignored", {63'd0, pkt_valid}, 64'd0);
    mode = 1;
    send_ts(15, 1);
    drain("bcast1_stall");
    chk("all_sent_once", 64'(sent_cnt), 64'd1);
    chk("idle_after_all", {63'd0, busy}, 64'd0);
    chk("ts_ready_after", {63'd0, ts_ready}, 64'd1);
    mode = 0;
    start_load();
    wr(30, 8'hFF);
    wr(0, 8'h11);
    wr(0, 8'h22);
    g0 = got.size();
    finish_load();
    load_start = 1;
    cyc();
    load_start = 0;
    send_ts(15, 0);
    drain("overwrite");
    chk("overwrite_pkt0", {31'd0, got[g0]}, 64'h0A0030222);
    send_ts(15, 1);
    drain("overwrite_ts1");
    chk("all_sent_two", 64'(sent_cnt), 64'd2);
    for (int it = 0; it < 3; it++) begin
      mode = 2;
      start_load();
      repeat ($urandom_range(10, 30)) wr($urandom_range(0, 31), $urandom_range(0, 255));
      finish_load();
      drain("rand_ts0");
      send_ts($urandom_range(0, 14), 0);
      send_ts(15, 1);
      drain("rand_ts1");
    end
    chk("all_sent_rand", 64'(sent_cnt), 64'd5);
    mode = 3;
    pkt_ready = 1;
    start_load();
    finish_load();
    repeat (5) cyc();
    pkt_ready = 0;
    cyc();
    rst_n = 0;
    cyc();
    chk("midrst_valid", {63'd0, pkt_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_ts_ready", {63'd0, ts_ready}, 64'd0);
    chk("midrst_pending", 64'(exp_q.size()), 64'd5);
    exp_q.delete();
    rst_n = 1;
    mode = 0;
    cyc();
    start_load();
    finish_load();
    drain("preserved");
    send_ts(15, 1);
    drain("preserved_ts1");
    chk("all_sent_final", 64'(sent_cnt), 64'd6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wmem_sched.md
WMEM_SCHED -- requirements
Module: wmem_sched

Interface
REQ-001 Parameters SHALL be: FILTER_SIZE, default 5, filter side length (weights = FILTER_SIZE^2); WEIGHT_WIDTH, default 8, bits per weight; FIRST_PPE, default 5, router address of the first PPE; NUM_TIMESTEPS, default 2, number of weight broadcasts per load.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- load_start  in  1  one-cycle pulse that opens a load.
- wr_valid  in  1  weight write valid.
- wr_ready  out  1  weight write ready.
- wr_addr  in  5  weight index, 0..24.
- wr_data  in  WEIGHT_WIDTH  weight value.
- load_done  in  1  one-cycle pulse that closes a load.
- pkt_valid  out  1  router packet valid.
- pkt_ready  in  1  router packet ready.
- pkt_data  out  33  packet: [32:29] dest, [28:25] opcode, [24:0] data.
- ts_valid  in  1  incoming router packet valid.
- ts_ready  out  1  incoming router packet ready.
- ts_data  in  33  incoming router packet, same format.
- busy  out  1  high in every state except IDLE.
- all_sent  out  1  one-cycle pulse after the final packet of the final timestep.

Function
REQ-003 Storage SHALL be a 25 x WEIGHT_WIDTH register array with no reset.
REQ-004 FSM states SHALL be IDLE, LOAD, SEND_A, SEND_B, WAIT_TS.
REQ-005 IDLE -> LOAD SHALL occur on load_start; load_start in any other state SHALL be ignored.
REQ-006 In LOAD, wr_ready SHALL be 1, and each cycle with wr_valid=1 SHALL write wr_data to storage[wr_addr].
REQ-007 A write with wr_addr > 24 SHALL be dropped; a repeated address SHALL overwrite.
REQ-008 In LOAD, load_done SHALL move to SEND_A with row=0 and ts_cnt=0; a write in the same cycle SHALL still commit.
REQ-009 In SEND_A, pkt_data SHALL be {FIRST_PPE+row, 4'd0, 1'b0, w[5r+2], w[5r+1], w[5r]}.
REQ-010 In SEND_B, pkt_data SHALL be {FIRST_PPE+row, 4'd0, 9'd0, w[5r+4], w[5r+3]}.
REQ-011 pkt_valid SHALL be 1 only in SEND_A and SEND_B, and SHALL be driven from registers.
REQ-012 Once pkt_valid rises, pkt_valid and pkt_data SHALL hold until pkt_ready=1, and a transfer SHALL occur on any cycle with valid and ready both 1.
REQ-013 A transfer in SEND_A SHALL go to SEND_B on the next cycle (zero bubble).
REQ-014 A transfer in SEND_B with row < 4 SHALL increment row and go to SEND_A.
REQ-015 A transfer in SEND_B with row = 4 SHALL:
- go to WAIT_TS if ts_cnt < NUM_TIMESTEPS-1;
- otherwise pulse all_sent and return to IDLE.
REQ-016 ts_ready SHALL be 1 in all states, so incoming packets are always consumed.
REQ-017 Only a packet accepted in WAIT_TS with opcode 15 SHALL act; it SHALL increment ts_cnt, clear row and go to SEND_A. Any other accepted packet SHALL be discarded.
REQ-018 Per broadcast, exactly 2*FILTER_SIZE packets SHALL be sent; the dest field SHALL wrap modulo 16.
REQ-019 The first pkt_valid SHALL rise on the cycle after load_done is sampled.

Reset
REQ-020 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE, with row=0, ts_cnt=0, pkt_valid=0, pkt_data=0, wr_ready=0, busy=0 and all_sent=0.
REQ-021 Reset mid-operation SHALL abandon any pending packet with no further transfer, and SHALL leave storage contents unchanged.
REQ-022 ts_ready SHALL be 0 while rst_n=0.

Structure
REQ-023 The shared package SHALL hold:
- packet field bounds (32/29/28/25/24/0);
- OP_WEIGHT=0 and OP_TIMESTEP_DONE=15;
- the state enum type;
- a function packing dest, opcode and data into a 33-bit packet.
REQ-024 One sub-module, wmem_pkt_reg, SHALL hold the packet output register and its valid/ready logic.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Write w[k]=k+1 for k=0..24, then load_done, pkt_ready=1 -> first two packets 0x0A0030201 and 0x0A0000504; ninth 0x120171615; tenth 0x120001918; then state WAIT_TS.
- Same load, pkt_ready toggling 1-of-3 cycles -> the same 10 packets in the same order, with pkt_data stable while stalled.
- In WAIT_TS, send opcode 3, then opcode 15 -> opcode 3 ignored; opcode 15 starts a repeat of the 10 packets, then all_sent pulses once and state returns to IDLE.
- In LOAD, write addr 30 value 0xFF, then addr 0 value 0x11 twice with the second set to 0x22 -> addr 30 dropped; first packet data 0x0302 22 (w0=0x22).
- Drop rst_n during SEND_B of row 2 -> next cycle pkt_valid=0 and busy=0; load_start followed by load_done with no writes -> packets carry the preserved weights.
- Assert load_start in SEND_A -> ignored, and the packet sequence is unchanged.
